// File: rtl/wave_array_stepper.sv
// wave_array_stepper: N-cell 1D damped wave field (u, du) advanced n_steps time steps, one cell per clock.
// Ports: start/n_steps launch a run and busy/done report it; wr_en/wr_sel/wr_addr/wr_data load u or du while
// idle; rd_addr selects the cell returned on rd_data_u/rd_data_du one cycle later.
// Define WAVE_SAT_EN to clamp written-back u/du to the signed DATA_W range instead of wrapping.
module wave_array_stepper #(
  parameter int N_CELLS    = 100,
  parameter int DATA_W     = 32,
  parameter int LAP_SHIFT  = 6,
  parameter int DU_SHIFT   = 8,
  parameter int DAMP_NUM   = 2047,
  parameter int DAMP_SHIFT = 11,
  parameter int BOUNDARY   = 0,
  parameter int STEP_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [STEP_W-1:0]                 n_steps,
  output logic                              busy,
  output logic                              done,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(N_CELLS)-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0]          wr_data,
  input  logic [$clog2(N_CELLS)-1:0]        rd_addr,
  output logic signed [DATA_W-1:0]          rd_data_u,
  output logic signed [DATA_W-1:0]          rd_data_du
);
  localparam int ADDR_W = $clog2(N_CELLS);
  localparam int IW = DATA_W + DAMP_SHIFT + 2;
  localparam logic signed [IW-1:0] DN = IW'(DAMP_NUM);
  localparam logic signed [IW-1:0] MAXV = {{(IW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = ~MAXV;
`ifdef WAVE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PRIME, SWEEP, DONE} state_t;
  state_t state, state_nxt;
  logic signed [DATA_W-1:0] u [N_CELLS];
  logic signed [DATA_W-1:0] du [N_CELLS];
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [STEP_W-1:0] steps;
  logic signed [DATA_W-1:0] u_left, u0_lat, uc, ucd, ur, u_new, du_new;
  logic signed [IW-1:0] lap, d, dun, s, un;
  logic last;
  function automatic logic signed [DATA_W-1:0] fit(input logic signed [IW-1:0] v);
    return (SAT && v > MAXV) ? MAXV[DATA_W-1:0] : (SAT && v < MINV) ? MINV[DATA_W-1:0] : v[DATA_W-1:0];
  endfunction
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = start ? ((n_steps == '0) ? DONE : PRIME) : IDLE;
      PRIME: state_nxt = SWEEP;
      SWEEP: state_nxt = last ? ((steps == STEP_W'(1)) ? DONE : PRIME) : SWEEP;
      DONE:  state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == PRIME) || (state == SWEEP);
    done = state == DONE;
  end
  // Right neighbour still holds its pre-step value; the left one was saved in u_left before being overwritten.
  always_comb begin
    last = idx == ADDR_W'(N_CELLS - 1);
    idx_nxt = idx + 1'b1;
    uc = u[idx];
    ucd = du[idx];
    ur = last ? ((BOUNDARY != 0) ? u0_lat : '0) : u[idx_nxt];
    lap = u_left + ur - (uc <<< 1);
    d = lap >>> LAP_SHIFT;
    d = (d == '1) ? '0 : d;
    dun = ucd + d;
    s = uc + (ucd >>> DU_SHIFT);
    un = (s * DN) >>> DAMP_SHIFT;
    u_new = fit(un);
    du_new = fit(dun);
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < N_CELLS; i++) begin
        u[i] <= '0;
        du[i] <= '0;
      end
      idx <= '0;
      steps <= '0;
      u_left <= '0;
      u0_lat <= '0;
      rd_data_u <= '0;
      rd_data_du <= '0;
    end else begin
      rd_data_u <= (int'(rd_addr) < N_CELLS) ? u[rd_addr] : '0;
      rd_data_du <= (int'(rd_addr) < N_CELLS) ? du[rd_addr] : '0;
      unique case (state)
        IDLE:
          if (start) steps <= n_steps;
          else if (wr_en && int'(wr_addr) < N_CELLS) begin
            if (wr_sel) du[wr_addr] <= wr_data;
            else u[wr_addr] <= wr_data;
          end
        PRIME: begin
          u0_lat <= u[0];
          u_left <= (BOUNDARY != 0) ? u[N_CELLS-1] : '0;
          idx <= '0;
        end
        SWEEP: begin
          u[idx] <= u_new;
          du[idx] <= du_new;
          u_left <= uc;
          idx <= idx_nxt;
          if (last) steps <= steps - 1'b1;
        end
        DONE: ;
      endcase
    end
endmodule

// File: tb/tb_wave_array_stepper.sv
// tb_wave_array_stepper: directed vector bench for wave_array_stepper (N_CELLS=4; fixed, periodic and 16-bit instances)
module tb_wave_array_stepper;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
  logic [15:0] n_steps = '0;
  logic [1:0] wr_addr = '0, rd_addr = '0;
  logic signed [31:0] wr_data = '0;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic signed [31:0] ru0, rdu0, ru1, rdu1;
  logic signed [15:0] ru2, rdu2;
  int checks = 0, failures = 0;
`ifdef WAVE_SAT_EN
  localparam int SAT_U = 32767;
`else
  localparam int SAT_U = -32659;
`endif
  always #5 clk = ~clk;
  wave_array_stepper #(.N_CELLS(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .busy(busy0), .done(done0),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data_u(ru0), .rd_data_du(rdu0));
  wave_array_stepper #(.N_CELLS(4), .BOUNDARY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .busy(busy1), .done(done1),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data_u(ru1), .rd_data_du(rdu1));
  wave_array_stepper #(.N_CELLS(4), .DATA_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .busy(busy2), .done(done2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
    .rd_addr(rd_addr), .rd_data_u(ru2), .rd_data_du(rdu2));
  typedef struct {
    int dut;
    int addr;
    int ld_u;
    int ld_du;
    logic [0:3][31:0] eu;
    logic [0:3][31:0] edu;
  } vec_t;
  vec_t vecs [6];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  task automatic wr(input bit sel, input int a, input int d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = a[1:0];
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask
  task automatic rd(input int dsel, input int a, output int ru, output int rdu);
    rd_addr = a[1:0];
    tick;
    ru = (dsel == 0) ? int'(ru0) : (dsel == 1) ? int'(ru1) : int'(ru2);
    rdu = (dsel == 0) ? int'(rdu0) : (dsel == 1) ? int'(rdu1) : int'(rdu2);
  endtask
  task automatic run(input int n, output int cyc);
    start = 1'b1;
    n_steps = n[15:0];
    tick;
    start = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 200) begin
      tick;
      cyc++;
    end
  endtask
  initial begin
    int cyc, ru, rdu;
    bit seen;
    vecs[0] = '{0, 2,  256,     0, '{0, 0, 255, 0},       '{0, 4, -8, 4}};
    vecs[1] = '{1, 0,  256,     0, '{255, 0, 0, 0},       '{-8, 4, 0, 4}};
    vecs[2] = '{0, 1,    1,     0, '{0, 0, 0, 0},         '{0, 0, 0, 0}};
    vecs[3] = '{2, 1, 32767, 32767, '{0, SAT_U, 0, 0},    '{511, 31743, 511, 0}};
    vecs[4] = '{0, 3, -256,     0, '{0, 0, 0, -256},      '{0, 0, -4, 8}};
    vecs[5] = '{0, 1,    0,   512, '{0, 1, 0, 0},         '{0, 512, 0, 0}};
    do_reset;
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_rd_u", int'(ru0), 0);
    check("reset_rd_du", int'(rdu0), 0);
    for (int a = 0; a < 4; a++) begin
      rd(0, a, ru, rdu);
      check($sformatf("reset_u%0d", a), ru, 0);
      check($sformatf("reset_du%0d", a), rdu, 0);
    end
    run(0, cyc);
    check("zero_steps_done_cycle", cyc, 1);
    tick;
    check("zero_steps_done_pulse", int'(done0), 0);
    foreach (vecs[v]) begin
      do_reset;
      wr(1'b0, vecs[v].addr, vecs[v].ld_u);
      wr(1'b1, vecs[v].addr, vecs[v].ld_du);
      run(1, cyc);
      check($sformatf("v%0d_done_cycle", v), cyc, 6);
      tick;
      check($sformatf("v%0d_done_pulse", v), int'(done0 | busy0), 0);
      for (int c = 0; c < 4; c++) begin
        rd(vecs[v].dut, c, ru, rdu);
        check($sformatf("v%0d_u%0d", v, c), ru, int'(vecs[v].eu[c]));
        check($sformatf("v%0d_du%0d", v, c), rdu, int'(vecs[v].edu[c]));
      end
    end
    do_reset;
    wr(1'b0, 2, 256);
    start = 1'b1;
    wr_en = 1'b1;
    wr_sel = 1'b0;
    wr_addr = 2'd0;
    wr_data = 77;
    n_steps = 16'd1;
    tick;
    start = 1'b0;
    check("start_busy", int'(busy0), 1);
    tick;
    tick;
    start = 1'b1;
    n_steps = 16'd3;
    wr_addr = 2'd1;
    wr_data = 999;
    tick;
    start = 1'b0;
    wr_en = 1'b0;
    cyc = 4;
    while (!done0 && cyc < 200) begin
      tick;
      cyc++;
    end
    check("midrun_done_cycle", cyc, 6);
    tick;
    for (int c = 0; c < 4; c++) begin
      rd(0, c, ru, rdu);
      check($sformatf("midrun_u%0d", c), ru, int'(vecs[0].eu[c]));
      check($sformatf("midrun_du%0d", c), rdu, int'(vecs[0].edu[c]));
    end
    do_reset;
    wr(1'b0, 2, 256);
    start = 1'b1;
    n_steps = 16'd1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("abort_busy_before", int'(busy0), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy_after", int'(busy0), 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen = seen | done0;
      tick;
    end
    check("abort_no_done", int'(seen), 0);
    for (int c = 0; c < 4; c++) begin
      rd(0, c, ru, rdu);
      check($sformatf("abort_u%0d", c), ru, 0);
      check($sformatf("abort_du%0d", c), rdu, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
